// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch front end: PCSel codes (owned jointly with
// the PC selector), fetch FSM states and default reset/exception addresses.
package pc_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    PCSEL_PC4    = 3'b000,
    PCSEL_IMMJ   = 3'b001,
    PCSEL_EPC    = 3'b010,
    PCSEL_EXC    = 3'b011,
    PCSEL_BRANCH = 3'b100,
    PCSEL_JR     = 3'b101
  } pcsel_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  function automatic logic [31:0] pc_add4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_mux.sv
// pc_next_mux: decodes the PCSel redirect code into {redirect, target}.
// Undefined codes (110/111) behave like sequential PC4.
module pc_next_mux
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [2:0]  PCSel,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JRAddr,
  input  logic [31:0] EPCAddr,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = 1'b0;
    target   = '0;
    case (PCSel)
      PCSEL_IMMJ:   begin redirect = 1'b1; target = JumpAddr;   end
      PCSEL_EPC:    begin redirect = 1'b1; target = EPCAddr;    end
      PCSEL_EXC:    begin redirect = 1'b1; target = EXC_VECTOR; end
      PCSEL_BRANCH: begin redirect = 1'b1; target = BranchAddr; end
      PCSEL_JR:     begin redirect = 1'b1; target = JRAddr;     end
      default:      ;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch front end: one outstanding SRAM-like request, one-deep
// output buffer to IF/ID, redirect flush. Optional PCFETCH_ADEL_EN flags misaligned PCs.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  PCSel,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JRAddr,
  input  logic [31:0] EPCAddr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        IF_Valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instr,
  output logic        IF_AdEL,
  input  logic        ID_Ready
);

`ifdef PCFETCH_ADEL_EN
  localparam logic ADEL_EN = 1'b1;
`else
  localparam logic ADEL_EN = 1'b0;
`endif

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  fetch_pc;
  logic [31:0]  pend_pc;
  logic         pend_v;
  logic         discard;
  logic [31:0]  buf_pc;
  logic [31:0]  buf_instr;
  logic         buf_adel;

  logic         redirect;
  logic [31:0]  target;
  logic         misaligned;

  pc_next_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_mux (
    .PCSel      (PCSel),
    .JumpAddr   (JumpAddr),
    .BranchAddr (BranchAddr),
    .JRAddr     (JRAddr),
    .EPCAddr    (EPCAddr),
    .redirect   (redirect),
    .target     (target)
  );

  assign misaligned = ADEL_EN && (pc[1:0] != 2'b00);

  assign inst_req  = resetn && (state == S_REQ) && !misaligned;
  assign inst_addr = ADEL_EN ? pc : {pc[31:2], 2'b00};

  assign IF_Valid = (state == S_HOLD);
  assign IF_PC    = buf_pc;
  assign IF_Instr = buf_instr;
  assign IF_AdEL  = buf_adel && ADEL_EN;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      fetch_pc  <= '0;
      pend_pc   <= '0;
      pend_v    <= 1'b0;
      discard   <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
      buf_adel  <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (misaligned) begin
            // No bus request was issued, so a redirect simply replaces the PC.
            if (redirect) begin
              pc <= target;
            end else begin
              buf_pc    <= pc;
              buf_instr <= '0;
              buf_adel  <= 1'b1;
              state     <= S_HOLD;
            end
          end else if (inst_addr_ok) begin
            fetch_pc <= pc;
            pend_v   <= 1'b0;
            state    <= S_WAIT;
            if (redirect) begin
              discard <= 1'b1;
              pc      <= target;
            end else if (pend_v) begin
              discard <= 1'b1;
              pc      <= pend_pc;
            end else begin
              pc <= pc_add4(pc);
            end
          end else if (redirect) begin
            // inst_addr must hold until accepted; park the target.
            pend_v  <= 1'b1;
            pend_pc <= target;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            state   <= S_REQ;
            discard <= 1'b0;
            if (redirect) begin
              pc <= target;
            end else if (!discard) begin
              buf_pc    <= fetch_pc;
              buf_instr <= inst_rdata;
              buf_adel  <= 1'b0;
              state     <= S_HOLD;
            end
          end else if (redirect) begin
            discard <= 1'b1;
            pc      <= target;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= S_REQ;
          end else if (ID_Ready) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl with hand-written reset and
// misaligned-fetch sequences.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  PCSel = '0;
  logic [31:0] JumpAddr = 32'hFFFF_FFFC;
  logic [31:0] BranchAddr = 32'h8000_1000;
  logic [31:0] JRAddr = 32'h0040_0000;
  logic [31:0] EPCAddr = 32'h0000_0100;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        IF_Valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instr;
  logic        IF_AdEL;
  logic        ID_Ready = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .PCSel        (PCSel),
    .JumpAddr     (JumpAddr),
    .BranchAddr   (BranchAddr),
    .JRAddr       (JRAddr),
    .EPCAddr      (EPCAddr),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .IF_Valid     (IF_Valid),
    .IF_PC        (IF_PC),
    .IF_Instr     (IF_Instr),
    .IF_AdEL      (IF_AdEL),
    .ID_Ready     (ID_Ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  localparam int NV = 45;
  vec_t v [NV];

  function automatic vec_t mk(input logic [2:0] sel, input logic aok, input logic dok,
                              input logic [31:0] rdata, input logic rdy,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic [31:0] epc,
                              input logic [31:0] einstr);
    vec_t r;
    r.sel = sel; r.aok = aok; r.dok = dok; r.rdata = rdata; r.rdy = rdy;
    r.ereq = ereq; r.eaddr = eaddr; r.evalid = evalid; r.epc = epc; r.einstr = einstr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic aok, input logic dok,
                       input logic [31:0] rdata, input logic rdy);
    PCSel = sel; inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rdata; ID_Ready = rdy;
  endtask

  initial begin
    // sel aok dok rdata rdy | req addr valid pc instr
    v[0]  = mk(3'd0, 1, 0, 0, 0,            1, 32'hBFC0_0000, 0, 0, 0);
    v[1]  = mk(3'd0, 0, 1, 32'h1111_0000, 0, 0, 0, 0, 0, 0);
    v[2]  = mk(3'd0, 0, 0, 0, 1,            0, 0, 1, 32'hBFC0_0000, 32'h1111_0000);
    v[3]  = mk(3'd0, 1, 0, 0, 0,            1, 32'hBFC0_0004, 0, 0, 0);
    v[4]  = mk(3'd0, 0, 1, 32'h2222_0001, 0, 0, 0, 0, 0, 0);
    v[5]  = mk(3'd0, 0, 0, 0, 1,            0, 0, 1, 32'hBFC0_0004, 32'h2222_0001);
    v[6]  = mk(3'd0, 1, 0, 0, 0,            1, 32'hBFC0_0008, 0, 0, 0);
    v[7]  = mk(3'd0, 0, 1, 32'h3333_0002, 0, 0, 0, 0, 0, 0);
    v[8]  = mk(3'd0, 0, 0, 0, 1,            0, 0, 1, 32'hBFC0_0008, 32'h3333_0002);
    v[9]  = mk(3'd0, 1, 0, 0, 0,            1, 32'hBFC0_000C, 0, 0, 0);
    v[10] = mk(3'd4, 0, 0, 0, 0,            0, 0, 0, 0, 0);
    v[11] = mk(3'd0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    v[12] = mk(3'd0, 1, 0, 0, 0,            1, 32'h8000_1000, 0, 0, 0);
    v[13] = mk(3'd0, 0, 1, 32'h4444_0003, 0, 0, 0, 0, 0, 0);
    v[14] = mk(3'd0, 0, 0, 0, 0,            0, 0, 1, 32'h8000_1000, 32'h4444_0003);
    v[15] = mk(3'd0, 0, 0, 0, 0,            0, 0, 1, 32'h8000_1000, 32'h4444_0003);
    v[16] = mk(3'd0, 0, 0, 0, 0,            0, 0, 1, 32'h8000_1000, 32'h4444_0003);
    v[17] = mk(3'd0, 0, 0, 0, 0,            0, 0, 1, 32'h8000_1000, 32'h4444_0003);
    v[18] = mk(3'd0, 0, 0, 0, 0,            0, 0, 1, 32'h8000_1000, 32'h4444_0003);
    v[19] = mk(3'd5, 0, 0, 0, 1,            0, 0, 1, 32'h8000_1000, 32'h4444_0003);
    v[20] = mk(3'd3, 0, 0, 0, 0,            1, 32'h0040_0000, 0, 0, 0);
    v[21] = mk(3'd0, 0, 0, 0, 0,            1, 32'h0040_0000, 0, 0, 0);
    v[22] = mk(3'd0, 0, 0, 0, 0,            1, 32'h0040_0000, 0, 0, 0);
    v[23] = mk(3'd0, 1, 0, 0, 0,            1, 32'h0040_0000, 0, 0, 0);
    v[24] = mk(3'd0, 0, 1, 32'hBAD0_0BAD, 0, 0, 0, 0, 0, 0);
    v[25] = mk(3'd0, 1, 0, 0, 0,            1, 32'hBFC0_0380, 0, 0, 0);
    v[26] = mk(3'd0, 0, 1, 32'h5555_0004, 0, 0, 0, 0, 0, 0);
    v[27] = mk(3'd1, 0, 0, 0, 1,            0, 0, 1, 32'hBFC0_0380, 32'h5555_0004);
    v[28] = mk(3'd2, 1, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0, 0);
    v[29] = mk(3'd6, 0, 1, 32'hBAD1_0BAD, 0, 0, 0, 0, 0, 0);
    v[30] = mk(3'd4, 0, 0, 0, 0,            1, 32'h0000_0100, 0, 0, 0);
    v[31] = mk(3'd5, 0, 0, 0, 0,            1, 32'h0000_0100, 0, 0, 0);
    v[32] = mk(3'd0, 1, 0, 0, 0,            1, 32'h0000_0100, 0, 0, 0);
    v[33] = mk(3'd0, 0, 1, 32'hBAD2_0BAD, 0, 0, 0, 0, 0, 0);
    v[34] = mk(3'd0, 1, 0, 0, 0,            1, 32'h0040_0000, 0, 0, 0);
    v[35] = mk(3'd0, 0, 1, 32'h6666_0005, 0, 0, 0, 0, 0, 0);
    v[36] = mk(3'd0, 0, 0, 0, 1,            0, 0, 1, 32'h0040_0000, 32'h6666_0005);
    v[37] = mk(3'd6, 0, 0, 0, 0,            1, 32'h0040_0004, 0, 0, 0);
    v[38] = mk(3'd7, 1, 0, 0, 0,            1, 32'h0040_0004, 0, 0, 0);
    v[39] = mk(3'd0, 0, 1, 32'h7777_0006, 0, 0, 0, 0, 0, 0);
    v[40] = mk(3'd1, 0, 0, 0, 1,            0, 0, 1, 32'h0040_0004, 32'h7777_0006);
    v[41] = mk(3'd0, 1, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0, 0);
    v[42] = mk(3'd0, 0, 1, 32'h8888_0007, 0, 0, 0, 0, 0, 0);
    v[43] = mk(3'd0, 0, 0, 0, 1,            0, 0, 1, 32'hFFFF_FFFC, 32'h8888_0007);
    v[44] = mk(3'd0, 1, 0, 0, 0,            1, 32'h0000_0000, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_valid", {31'd0, IF_Valid}, 32'd0);
    chk("rst_pc", IF_PC, 32'd0);
    chk("rst_instr", IF_Instr, 32'd0);
    chk("rst_adel", {31'd0, IF_AdEL}, 32'd0);
    resetn = 1'b1;
    #1;
    chk("rel_req", {31'd0, inst_req}, 32'd1);
    chk("rel_addr", inst_addr, 32'hBFC0_0000);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'd0, inst_req}, {31'd0, v[i].ereq});
      if (v[i].ereq) chk($sformatf("v%0d_addr", i), inst_addr, v[i].eaddr);
      chk($sformatf("v%0d_valid", i), {31'd0, IF_Valid}, {31'd0, v[i].evalid});
      if (v[i].evalid) begin
        chk($sformatf("v%0d_ifpc", i), IF_PC, v[i].epc);
        chk($sformatf("v%0d_instr", i), IF_Instr, v[i].einstr);
        chk($sformatf("v%0d_adel", i), {31'd0, IF_AdEL}, 32'd0);
      end
      drive(v[i].sel, v[i].aok, v[i].dok, v[i].rdata, v[i].rdy);
    end

    // Reset asserted while in S_WAIT, stray data_ok after release
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 0);
    chk("wait_req", {31'd0, inst_req}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, inst_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, IF_Valid}, 32'd0);
    chk("mid_rst_ifpc", IF_PC, 32'd0);
    chk("mid_rst_instr", IF_Instr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    drive(3'd0, 0, 1, 32'hFACE_FACE, 0);
    #1;
    chk("rel2_req", {31'd0, inst_req}, 32'd1);
    chk("rel2_addr", inst_addr, 32'hBFC0_0000);
    @(negedge clk);
    chk("stray_req", {31'd0, inst_req}, 32'd1);
    chk("stray_addr", inst_addr, 32'hBFC0_0000);
    chk("stray_valid", {31'd0, IF_Valid}, 32'd0);
    drive(3'd0, 1, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_wait_req", {31'd0, inst_req}, 32'd0);
    drive(3'd0, 0, 1, 32'hCAFE_0001, 0);
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 0);
    chk("post_rst_valid", {31'd0, IF_Valid}, 32'd1);
    chk("post_rst_ifpc", IF_PC, 32'hBFC0_0000);
    chk("post_rst_instr", IF_Instr, 32'hCAFE_0001);

`ifdef PCFETCH_ADEL_EN
    // Misaligned JR target: no bus request, error presented to ID
    JRAddr = 32'h0040_0002;
    drive(3'd5, 0, 0, 0, 0);
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 0);
    chk("adel_req0", {31'd0, inst_req}, 32'd0);
    chk("adel_valid0", {31'd0, IF_Valid}, 32'd0);
    @(negedge clk);
    chk("adel_req1", {31'd0, inst_req}, 32'd0);
    chk("adel_valid", {31'd0, IF_Valid}, 32'd1);
    chk("adel_flag", {31'd0, IF_AdEL}, 32'd1);
    chk("adel_ifpc", IF_PC, 32'h0040_0002);
    chk("adel_instr", IF_Instr, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Instruction-fetch front end: holds the architectural PC, consumes the 3-bit `PCSel` redirect code from the PC selector together with the candidate targets, and drives the SRAM-like instruction bus with one outstanding request. Returned instructions are buffered one deep and presented to the IF/ID register under a valid/ready handshake. Any redirect flushes wrong-path fetches, whether in flight or buffered.

## Interface
- `RESET_PC`, 32'hBFC0_0000, PC after reset.
- `EXC_VECTOR`, 32'hBFC0_0380, target when `PCSel`=Except.
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `PCSel`  in  3  000 PC4, 001 ImmeJump, 010 EPC, 011 Except, 100 Branch, 101 JR; 110/111 treated as PC4.
- `JumpAddr`, `BranchAddr`, `JRAddr`, `EPCAddr`  in  32 each  redirect targets, sampled only in the redirect cycle.
- `inst_req`  out  1  fetch request.
- `inst_addr`  out  32  fetch address, stable while `inst_req`=1 and not accepted.
- `inst_addr_ok`  in  1  request accepted.
- `inst_data_ok`  in  1  read data valid.
- `inst_rdata`  in  32  read data.
- `IF_Valid`  out  1  instruction presented to ID.
- `IF_PC`  out  32  PC of the presented instruction.
- `IF_Instr`  out  32  presented instruction.
- `IF_AdEL`  out  1  fetch address error flag.
- `ID_Ready`  in  1  ID accepts the instruction.

## Operation
- Redirect: `PCSel` is not PC4 (000) and not an undefined code. It is a one-cycle pulse. The target comes from the port matching `PCSel`; Except uses `EXC_VECTOR`.
- FSM states:
  - S_REQ: `inst_req`=1, `inst_addr`=PC. On `inst_addr_ok`, PC←PC+4 (wraps mod 2^32) and go to S_WAIT.
  - S_WAIT: `inst_req`=0. On `inst_data_ok`, a discarded fetch returns to S_REQ with discard cleared. Otherwise the buffer loads {PC of the fetch, `inst_rdata`} and the FSM goes to S_HOLD.
  - S_HOLD: `IF_Valid`=1. When `ID_Ready`=1 the buffer is consumed and the FSM goes to S_REQ.
- Redirect in S_REQ with `inst_addr_ok`: the accepted fetch is wrong-path. Set discard, PC←target.
- Redirect in S_REQ without `inst_addr_ok`: `inst_addr` must not change. The target is latched into pend_pc and pend_v is set. When `inst_addr_ok` arrives, set discard, PC←pend_pc, clear pend_v.
- Redirect in S_WAIT: set discard, PC←target. If it coincides with `inst_data_ok`, drop the data and go to S_REQ.
- Redirect in S_HOLD: drop the buffer (`IF_Valid`=0 next cycle), PC←target, go to S_REQ, even if `ID_Ready`=1 in the same cycle.
- Successive redirects: the later one overrides pend_pc.
- Outstanding requests: at most one. The returned PC is tracked in fetch_pc.

## Timing
- Reset values: `inst_req`=0 while `resetn`=0; `IF_Valid`=0, `IF_PC`=0, `IF_Instr`=0, `IF_AdEL`=0. Internal: PC=`RESET_PC`, state S_REQ, discard=0, pend_v=0.
- First cycle after release: `inst_req`=1, `inst_addr`=`RESET_PC`.
- Reset asserted mid-operation: all state returns to reset values immediately. A `inst_data_ok` after release without a preceding request is ignored.
- Latency: `inst_data_ok` at cycle n gives `IF_Valid` at n+1. Acceptance by `ID_Ready` at cycle m gives `inst_req` at m+1.
- Throughput with zero-wait memory: one instruction per 3 cycles.
- A redirect at cycle n gives `inst_addr`=target no later than the first S_REQ cycle after any outstanding fetch completes.

## Configuration
- `PCFETCH_ADEL_EN` defined, PC[1:0]≠0 in S_REQ:
  - no bus request is issued;
  - the buffer loads {PC, 32'h0}, `IF_AdEL`=1, and the FSM goes to S_HOLD;
  - a later redirect is then required to make progress.
- `PCFETCH_ADEL_EN` undefined: `inst_addr`={PC[31:2],2'b00}, `IF_AdEL` is tied 0, and misalignment is never flagged.

## Structure
- Shared package holds:
  - `PCSel` encodings, owned jointly with the PC selector;
  - the FSM state enum {S_REQ, S_WAIT, S_HOLD};
  - `RESET_PC` and `EXC_VECTOR` defaults.
- Sub-module `pc_next_mux`: combinational; maps `PCSel` and the targets to {redirect, target}.

## Test plan
- Reset release, memory acknowledges `inst_addr_ok` in 1 cycle and `inst_data_ok` next cycle, `ID_Ready`=1 -> fetch addresses BFC00000, BFC00004, BFC00008; `IF_PC` matches each fetch.
- Branch redirect (100) with `BranchAddr`=80001000 while in S_WAIT -> returned word is dropped (no `IF_Valid`), next `inst_addr`=80001000.
- Except redirect while `inst_req`=1 and `inst_addr_ok` held low 3 cycles -> `inst_addr` unchanged until accepted; that fetch is discarded; next `inst_addr`=BFC00380.
- S_HOLD with `ID_Ready`=0 for 5 cycles -> `IF_Valid`, `IF_PC`, `IF_Instr` stable and `inst_req`=0; then a JR redirect to 00400000 -> `IF_Valid`=0 next cycle, then fetch from 00400000.
- `PCFETCH_ADEL_EN` defined, JR to 00400002 -> no `inst_req`, `IF_Valid`=1 with `IF_AdEL`=1, `IF_PC`=00400002, `IF_Instr`=0.
- `resetn` dropped while in S_WAIT, then a stray `inst_data_ok` after release -> ignored; `inst_addr`=BFC00000.
